// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its operator panel:
// button, code and sensor inputs, plus the LED, digit and siren outputs.
interface alarm_controller_if;
  logic       arm_btn;
  logic       code_ok;
  logic       ir_trip;
  logic       led0;
  logic [7:0] hex1;
  logic [7:0] hex0;
  logic       siren;
  logic       armed;

  modport master (
    output arm_btn, code_ok, ir_trip,
    input  led0, hex1, hex0, siren, armed
  );

  modport slave (
    input  arm_btn, code_ok, ir_trip,
    output led0, hex1, hex0, siren, armed
  );
endinterface

// File: rtl/alarm_controller.sv
// Five-state arming sequencer with exit/entry countdowns on a one-second tick.
// Every output is registered from next-state values, so the display never lags the state.
module alarm_controller #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int EXIT_S      = 9,
  parameter int ENTRY_S     = 9
) (
  input logic              clk,
  input logic              rst,
  alarm_controller_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES);

  localparam logic [7:0] SEG_O = 8'hC0;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_N = 8'hAB;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_L = 8'hC7;

  typedef enum logic [2:0] {
    S_DISARMED, S_EXIT, S_ARMED, S_ENTRY, S_ALARM
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    count_reg, count_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic          blink_reg, blink_next;
  logic          arm_prev_reg;
  logic [7:0]    hex1_reg, hex1_next;
  logic [7:0]    hex0_reg, hex0_next;
  logic          led0_reg, led0_next;
  logic          siren_reg, siren_next;
  logic          armed_reg, armed_next;

  logic arm_edge;
  logic tick;
  logic counting;

  assign arm_edge = bus.arm_btn & ~arm_prev_reg;
  assign tick     = (pre_reg == PW'(TICK_CYCLES - 1));
  assign counting = (state_reg == S_EXIT) || (state_reg == S_ENTRY);

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd1:    digit_seg = 8'hF9;
      4'd2:    digit_seg = 8'hA4;
      4'd3:    digit_seg = 8'hB0;
      4'd4:    digit_seg = 8'h99;
      4'd5:    digit_seg = 8'h92;
      4'd6:    digit_seg = 8'h82;
      4'd7:    digit_seg = 8'hF8;
      4'd8:    digit_seg = 8'h80;
      4'd9:    digit_seg = 8'h90;
      default: digit_seg = SEG_O;
    endcase
  endfunction

  // State register plus the registered outputs, which load the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_DISARMED;
      count_reg    <= 4'd0;
      pre_reg      <= '0;
      blink_reg    <= 1'b0;
      arm_prev_reg <= 1'b1;
      hex1_reg     <= SEG_O;
      hex0_reg     <= SEG_F;
      led0_reg     <= 1'b0;
      siren_reg    <= 1'b0;
      armed_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      pre_reg      <= pre_next;
      blink_reg    <= blink_next;
      arm_prev_reg <= bus.arm_btn;
      hex1_reg     <= hex1_next;
      hex0_reg     <= hex0_next;
      led0_reg     <= led0_next;
      siren_reg    <= siren_next;
      armed_reg    <= armed_next;
    end
  end

  // code_ok is tested first in every armed-side state so a disarm beats expiry.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      S_DISARMED: begin
        if (arm_edge) begin
          state_next = S_EXIT;
          count_next = 4'(EXIT_S);
        end
      end
      S_EXIT, S_ENTRY: begin
        if (bus.code_ok) begin
          state_next = S_DISARMED;
        end else if (tick) begin
          if (count_reg == 4'd1)
            state_next = (state_reg == S_EXIT) ? S_ARMED : S_ALARM;
          else
            count_next = count_reg - 4'd1;
        end
      end
      S_ARMED: begin
        if (bus.code_ok) begin
          state_next = S_DISARMED;
        end else if (bus.ir_trip) begin
          state_next = S_ENTRY;
          count_next = 4'(ENTRY_S);
        end
      end
      S_ALARM: begin
        if (bus.code_ok)
          state_next = S_DISARMED;
      end
      default: state_next = S_DISARMED;
    endcase

    if (state_next != state_reg || tick)
      pre_next = '0;
    else
      pre_next = pre_reg + PW'(1);

    if (state_next != state_reg)
      blink_next = (state_next == S_EXIT) || (state_next == S_ENTRY);
    else if (tick && counting)
      blink_next = ~blink_reg;
    else
      blink_next = blink_reg;
  end

  always_comb begin
    hex1_next  = SEG_O;
    hex0_next  = SEG_F;
    led0_next  = 1'b0;
    siren_next = 1'b0;
    armed_next = 1'b0;
    case (state_next)
      S_EXIT: begin
        hex1_next = SEG_D;
        hex0_next = digit_seg(count_next);
        led0_next = blink_next;
      end
      S_ARMED: begin
        hex1_next  = SEG_O;
        hex0_next  = SEG_N;
        led0_next  = 1'b1;
        armed_next = 1'b1;
      end
      S_ENTRY: begin
        hex1_next  = SEG_E;
        hex0_next  = digit_seg(count_next);
        led0_next  = blink_next;
        armed_next = 1'b1;
      end
      S_ALARM: begin
        hex1_next  = SEG_A;
        hex0_next  = SEG_L;
        led0_next  = 1'b1;
        siren_next = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.hex1  = hex1_reg;
  assign bus.hex0  = hex0_reg;
  assign bus.led0  = led0_reg;
  assign bus.siren = siren_reg;
  assign bus.armed = armed_reg;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed and random stimulus for alarm_controller, checked every cycle against
// an elapsed-time model of the arming sequence.
module tb_alarm_controller;
  localparam int T   = 4;
  localparam int EXS = 3;
  localparam int ENS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  alarm_controller_if bus ();

  alarm_controller #(.TICK_CYCLES(T), .EXIT_S(EXS), .ENTRY_S(ENS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: current mode, cycles spent in it, and the seconds it started with.
  typedef enum int {M_DIS, M_EXIT, M_ARMED, M_ENTRY, M_ALARM} mstate_t;
  mstate_t m_st   = M_DIS;
  int      m_el   = 0;
  int      m_sec  = 0;
  bit      m_prev = 1'b1;

  logic [7:0] dig_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit a, input bit ok, input bit ir);
    bit      tk;
    int      remaining;
    mstate_t nx;
    if (r) begin
      m_st = M_DIS; m_el = 0; m_sec = 0; m_prev = 1'b1;
      return;
    end
    tk        = (m_el % T) == T - 1;
    remaining = m_sec - m_el / T;
    nx        = m_st;
    case (m_st)
      M_DIS:   if (a && !m_prev) begin nx = M_EXIT; m_sec = EXS; end
      M_EXIT:  if (ok) nx = M_DIS; else if (tk && remaining == 1) nx = M_ARMED;
      M_ARMED: if (ok) nx = M_DIS; else if (ir) begin nx = M_ENTRY; m_sec = ENS; end
      M_ENTRY: if (ok) nx = M_DIS; else if (tk && remaining == 1) nx = M_ALARM;
      M_ALARM: if (ok) nx = M_DIS;
      default: nx = M_DIS;
    endcase
    m_prev = a;
    m_el   = (nx != m_st) ? 0 : m_el + 1;
    m_st   = nx;
  endfunction

  task automatic compare_model();
    logic [7:0] e1, e0;
    logic       el, es, ea, bl;
    bl = ((m_el / T) % 2) == 0;
    e1 = 8'hC0; e0 = 8'h8E; el = 0; es = 0; ea = 0;
    case (m_st)
      M_EXIT:  begin e1 = 8'hA1; e0 = dig_tab[m_sec - m_el / T]; el = bl; end
      M_ARMED: begin e1 = 8'hC0; e0 = 8'hAB; el = 1; ea = 1; end
      M_ENTRY: begin e1 = 8'h86; e0 = dig_tab[m_sec - m_el / T]; el = bl; ea = 1; end
      M_ALARM: begin e1 = 8'h88; e0 = 8'hC7; el = 1; es = 1; end
      default: ;
    endcase
    check_eq("hex1",  32'(bus.hex1),  32'(e1));
    check_eq("hex0",  32'(bus.hex0),  32'(e0));
    check_eq("led0",  32'(bus.led0),  32'(el));
    check_eq("siren", 32'(bus.siren), 32'(es));
    check_eq("armed", 32'(bus.armed), 32'(ea));
  endtask

  task automatic step(input bit r, input bit a, input bit ok, input bit ir);
    rst = r; bus.arm_btn = a; bus.code_ok = ok; bus.ir_trip = ir;
    @(posedge clk);
    model_step(r, a, ok, ir);
    #1;
    cyc++;
    $display("cyc=%0d rst=%0b arm=%0b ok=%0b ir=%0b -> hex1=%h hex0=%h led0=%0b siren=%0b armed=%0b",
             cyc, r, a, ok, ir, bus.hex1, bus.hex0, bus.led0, bus.siren, bus.armed);
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic press();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_hex1"},  32'(bus.hex1),  32'h C0);
    check_eq({tag, "_hex0"},  32'(bus.hex0),  32'h 8E);
    check_eq({tag, "_siren"}, 32'(bus.siren), 32'h0);
    check_eq({tag, "_armed"}, 32'(bus.armed), 32'h0);
  endtask

  initial begin
    bit a_lvl, ir_lvl, r, ok;
    bus.arm_btn = 1'b1; bus.code_ok = 1'b0; bus.ir_trip = 1'b0;

    // Reset held with the button down, then button stays down: must stay disarmed.
    step(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_reset_vals("rst");
    check_eq("rst_led0", 32'(bus.led0), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check_reset_vals("rst_held_btn");

    // Exit countdown.
    press();
    check_eq("exit_hex1", 32'(bus.hex1), 32'hA1);
    check_eq("exit_hex0_3", 32'(bus.hex0), 32'hB0);
    check_eq("exit_led_on", 32'(bus.led0), 32'h1);
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, 0);
      if (i == 4) begin
        check_eq("exit_hex0_2", 32'(bus.hex0), 32'hA4);
        check_eq("exit_led_t1", 32'(bus.led0), 32'h0);
      end
      if (i == 8) begin
        check_eq("exit_hex0_1", 32'(bus.hex0), 32'hF9);
        check_eq("exit_led_t2", 32'(bus.led0), 32'h1);
      end
    end
    check_eq("armed_hex0", 32'(bus.hex0), 32'hAB);
    check_eq("armed_flag", 32'(bus.armed), 32'h1);

    // Entry to alarm, then disarm.
    step(0, 0, 0, 1);
    check_eq("entry_hex1", 32'(bus.hex1), 32'h86);
    check_eq("entry_hex0_2", 32'(bus.hex0), 32'hA4);
    idle(8);
    check_eq("alarm_hex1", 32'(bus.hex1), 32'h88);
    check_eq("alarm_siren", 32'(bus.siren), 32'h1);
    check_eq("alarm_armed", 32'(bus.armed), 32'h0);
    step(0, 0, 1, 0);
    check_reset_vals("alarm_disarm");

    // Race: code_ok coincides with the entry expiry tick.
    press(); idle(12);
    step(0, 0, 0, 1);
    idle(7);
    check_eq("race_pre_hex0", 32'(bus.hex0), 32'hF9);
    step(0, 0, 1, 0);
    check_reset_vals("race");

    // Held trip through exit: one cycle of ARMED, then ENTRY.
    press();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    check_eq("held_armed_hex0", 32'(bus.hex0), 32'hAB);
    step(0, 0, 0, 1);
    check_eq("held_entry_hex1", 32'(bus.hex1), 32'h86);
    check_eq("held_entry_hex0", 32'(bus.hex0), 32'hA4);
    step(0, 0, 1, 0);

    // Reset in ALARM, then reset in EXIT with count=2.
    press(); idle(12); step(0, 0, 0, 1); idle(8);
    check_eq("mid_alarm_siren", 32'(bus.siren), 32'h1);
    step(1, 0, 0, 0);
    check_reset_vals("rst_in_alarm");
    press();
    check_eq("rearm1_hex0", 32'(bus.hex0), 32'hB0);
    idle(4);
    check_eq("exit_cnt2_hex0", 32'(bus.hex0), 32'hA4);
    step(1, 0, 0, 0);
    check_reset_vals("rst_in_exit");
    press();
    check_eq("rearm2_hex0", 32'(bus.hex0), 32'hB0);
    step(0, 0, 1, 0);

    // Random traffic.
    a_lvl = 0; ir_lvl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 29) == 0) ir_lvl = ~ir_lvl;
      ok = ($urandom_range(0, 49) == 0);
      r  = ($urandom_range(0, 399) == 0);
      step(r, a_lvl, ok, ir_lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
